// File: rtl/pipe_hazard_ctrl_if.sv
// pipe_hazard_ctrl_if
//   Bundles the pipeline-facing signals of the hazard controller so the
//   stages, the PC unit and the memory controller connect to one port.
//   master : drives rdy, stall_req, flush_req, clr_cnt; observes the results
//   slave  : the controller; consumes requests, produces stall/bubble/flush,
//            busy and the two performance counters
interface pipe_hazard_ctrl_if #(
    parameter int NSTAGE = 6,
    parameter int CNT_W  = 32
);
    logic              rdy;
    logic [NSTAGE-1:0] stall_req;
    logic [NSTAGE-1:0] flush_req;
    logic              clr_cnt;
    logic [NSTAGE-1:0] stall;
    logic [NSTAGE-1:0] bubble;
    logic [NSTAGE-1:0] flush;
    logic              busy;
    logic [CNT_W-1:0]  stall_cnt;
    logic [CNT_W-1:0]  flush_cnt;

    modport master (
        output rdy, stall_req, flush_req, clr_cnt,
        input  stall, bubble, flush, busy, stall_cnt, flush_cnt
    );

    modport slave (
        input  rdy, stall_req, flush_req, clr_cnt,
        output stall, bubble, flush, busy, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl
//   Pipeline stall/flush controller. Stage 0 is the PC, stage NSTAGE-1 is
//   writeback; a higher index holds an older instruction.
//   - Stall priority: the oldest stalled stage holds itself and everything
//     younger, and the stage just above it emits a bubble.
//   - Flushes come from the oldest redirecting stage. If that stage is itself
//     held, the flush waits (PEND) until it can move; once taken, the flush
//     vector is held for FLUSH_CYCLES cycles (FLUSH).
//   - Saturating counters for stalled cycles and taken flushes.
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous reset, active low
//   bus  : pipe_hazard_ctrl_if.slave (rdy, stall_req, flush_req, clr_cnt in;
//          stall, bubble, flush, busy, stall_cnt, flush_cnt out)
module pipe_hazard_ctrl #(
    parameter int NSTAGE       = 6,
    parameter int FLUSH_CYCLES = 1,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst,
    pipe_hazard_ctrl_if.slave bus
);
    localparam int IW = (NSTAGE > 1) ? $clog2(NSTAGE) : 1;

    typedef enum logic [1:0] {IDLE, PEND, FLUSH} state_t;

    state_t            state;
    logic [IW-1:0]     pend_k;
    logic [3:0]        fcnt;
    logic [NSTAGE-1:0] flush_q;
    logic              busy_q;
    logic [CNT_W-1:0]  stall_cnt_q;
    logic [CNT_W-1:0]  flush_cnt_q;

    logic              any_stall;
    logic [IW-1:0]     h;
    logic              any_flush;
    logic [IW-1:0]     k;
    logic              new_req;
    logic [IW-1:0]     tgt_k;
    logic              tgt_blocked;
    logic              accept;
    logic [NSTAGE-1:0] prio_stall;
    logic [NSTAGE-1:0] prio_bubble;
    logic [NSTAGE-1:0] force_mask;
    logic [NSTAGE-1:0] stall_run;

    // Mask with every stage younger than idx set.
    function automatic logic [NSTAGE-1:0] below(input logic [IW-1:0] idx);
        logic [NSTAGE-1:0] m;
        m = '0;
        for (int i = 0; i < NSTAGE; i++) begin
            if (i < int'(idx)) m[i] = 1'b1;
        end
        return m;
    endfunction

    // Oldest stall request and oldest flush request; the loop runs upward so
    // the highest index wins.
    always_comb begin
        any_stall = 1'b0;
        h         = '0;
        any_flush = 1'b0;
        k         = '0;
        for (int s = 0; s < NSTAGE; s++) begin
            if (bus.stall_req[s]) begin
                any_stall = 1'b1;
                h         = IW'(s);
            end
            if (bus.flush_req[s]) begin
                any_flush = 1'b1;
                k         = IW'(s);
            end
        end
    end

    // A request only matters if it is older than the flush already tracked.
    // The flush target is blocked while the oldest stall sits at or above it,
    // because then the redirecting instruction itself cannot advance.
    always_comb begin
        new_req     = any_flush && ((state == IDLE) || (k > pend_k));
        tgt_k       = new_req ? k : pend_k;
        tgt_blocked = any_stall && (h >= tgt_k);
        case (state)
            IDLE:    accept = any_flush && !tgt_blocked;
            PEND:    accept = !tgt_blocked;
            default: accept = new_req && !tgt_blocked;
        endcase
    end

    // Priority stall/bubble, plus holding the wrong-path stages in the cycle a
    // flush is taken from IDLE or PEND so they do not advance before the kill.
    always_comb begin
        prio_stall  = '0;
        prio_bubble = '0;
        for (int i = 0; i < NSTAGE; i++) begin
            if (any_stall && (i <= int'(h)))     prio_stall[i]  = 1'b1;
            if (any_stall && (i == int'(h) + 1)) prio_bubble[i] = 1'b1;
        end
        force_mask = (accept && (state != FLUSH)) ? below(tgt_k) : '0;
        stall_run  = prio_stall | force_mask;
    end

    // Output gating: reset forces everything low, rdy=0 freezes the whole
    // pipe, and stages being killed never also emit a bubble.
    always_comb begin
        if (!rst) begin
            bus.stall  = '0;
            bus.bubble = '0;
            bus.flush  = '0;
        end else if (!bus.rdy) begin
            bus.stall  = '1;
            bus.bubble = '0;
            bus.flush  = '0;
        end else begin
            bus.stall  = stall_run;
            bus.bubble = prio_bubble & ~flush_q;
            bus.flush  = flush_q;
        end
        bus.busy      = busy_q;
        bus.stall_cnt = stall_cnt_q;
        bus.flush_cnt = flush_cnt_q;
    end

    // Flush sequencing FSM. flush_q and busy_q are registered alongside the
    // state so they change exactly when the state does.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            pend_k  <= '0;
            fcnt    <= '0;
            flush_q <= '0;
            busy_q  <= 1'b0;
        end else if (bus.rdy) begin
            case (state)
                IDLE: begin
                    if (any_flush) begin
                        pend_k <= k;
                        busy_q <= 1'b1;
                        if (accept) begin
                            state   <= FLUSH;
                            fcnt    <= 4'(FLUSH_CYCLES);
                            flush_q <= below(k);
                        end else begin
                            state <= PEND;
                        end
                    end
                end
                PEND: begin
                    pend_k <= tgt_k;
                    if (accept) begin
                        state   <= FLUSH;
                        fcnt    <= 4'(FLUSH_CYCLES);
                        flush_q <= below(tgt_k);
                    end
                end
                default: begin
                    if (new_req) begin
                        pend_k <= k;
                        if (accept) begin
                            fcnt    <= 4'(FLUSH_CYCLES);
                            flush_q <= below(k);
                        end else begin
                            state   <= PEND;
                            flush_q <= '0;
                        end
                    end else if (fcnt == 4'd1) begin
                        state   <= IDLE;
                        flush_q <= '0;
                        busy_q  <= 1'b0;
                    end else begin
                        fcnt <= fcnt - 4'd1;
                    end
                end
            endcase
        end
    end

    // Saturating performance counters; clear wins over increment and nothing
    // moves while rdy is low.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else if (bus.rdy) begin
            if (bus.clr_cnt) begin
                stall_cnt_q <= '0;
                flush_cnt_q <= '0;
            end else begin
                if ((|stall_run) && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
                if (accept && (flush_cnt_q != '1))       flush_cnt_q <= flush_cnt_q + CNT_W'(1);
            end
        end
    end
endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Parametrised pipeline stall/flush controller for the in-order core. It takes per-stage stall and flush requests and produces per-stage stall, bubble and flush vectors. It adds three things a purely combinational stall priority encoder cannot do: it defers flushes while the flushing stage is held, holds a flush for a configurable number of cycles, and keeps saturating performance counters. It sits between all pipeline stages, the PC unit and the memory controller.

Parameters:
NSTAGE, 6, number of controlled stages; index 0 = PC, NSTAGE-1 = writeback; higher index = older instruction.
FLUSH_CYCLES, 1, cycles the flush vector is held after a flush is taken; range 1..15.
CNT_W, 32, width of the performance counters.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  asynchronous, active-low reset (0 = reset).
rdy  in  1  global ready; 0 freezes the controller.
stall_req  in  NSTAGE  bit s = stage s cannot accept or advance this cycle.
flush_req  in  NSTAGE  bit k = stage k resolved a redirect; stages below k hold wrong-path work.
clr_cnt  in  1  synchronous clear of both counters.
stall  out  NSTAGE  bit i = hold stage i register.
bubble  out  NSTAGE  bit i = stage i inserts a NOP into its output this cycle.
flush  out  NSTAGE  bit i = kill the contents of stage i.
busy  out  1  state is PEND or FLUSH.
stall_cnt  out  CNT_W  cycles with any stall bit set while rdy=1.
flush_cnt  out  CNT_W  number of flushes taken.

Behaviour:
- Reset (rst=0, async): state=IDLE, pend_k=0, fcnt=0, both counters=0. All outputs are 0 during reset.
- rdy=0: stall = all ones; bubble=0; flush=0. State, fcnt, pend_k and counters are frozen. Operation resumes unchanged when rdy returns to 1.
- Stall priority (combinational, rdy=1): H = highest s with stall_req[s].
  - stall[i]=1 for all i<=H.
  - bubble[H+1]=1 if H<NSTAGE-1; all other bubble bits are 0.
  - No stall_req set: stall=0, bubble=0.
- Flush selection: K = highest k with flush_req[k]. Requests from lower indices are ignored because they come from younger, wrong-path instructions.
- A flush is "blocked" when H>=K, i.e. the flushing instruction is itself held.
- IDLE:
  - flush_req present and not blocked: the flush is accepted this cycle. Force stall[i]=1 for i<K (OR with stall priority). Latch pend_k=K, load fcnt=FLUSH_CYCLES, go to FLUSH, flush_cnt++.
  - flush_req present and blocked: latch pend_k=K, go to PEND. No flush_cnt increment.
- PEND:
  - stall[i]=1 forced for i<pend_k.
  - A new flush_req with K>pend_k replaces pend_k.
  - When H<pend_k: accept as in IDLE (load fcnt, go to FLUSH, flush_cnt++).
- FLUSH:
  - flush[i]=1 for i<pend_k. bubble is forced 0 for those bits. stall is from priority only.
  - fcnt decrements each rdy=1 cycle. At fcnt=1 go to IDLE next cycle.
  - A new flush_req with K>pend_k restarts: pend_k=K, fcnt=FLUSH_CYCLES, flush_cnt++. If it is blocked, go to PEND instead.
  - A new flush_req with K<=pend_k is ignored.
- Flush latency: request cycle N → flush asserted in cycles N+1 .. N+FLUSH_CYCLES.
- busy = (state != IDLE).
- Counters:
  - Saturate at all-ones; they never wrap.
  - clr_cnt takes priority over increment in the same cycle.
  - stall_cnt increments when rdy=1 and |stall.
- Reset mid-FLUSH or mid-PEND aborts immediately; the pending flush is lost.

Test Plan:
- Reset, then stall_req=6'b010000 with rdy=1 → stall=6'b011111, bubble=6'b100000, stall_cnt increments by 1 per cycle; drop rst to 0 mid-run → all outputs 0 asynchronously.
- flush_req=6'b000100 for 1 cycle, no stalls, FLUSH_CYCLES=1 → request cycle stall=6'b000011; next cycle flush=6'b000011; then IDLE; flush_cnt=1, busy high exactly 1 cycle.
- stall_req[4]=1 held 3 cycles with flush_req[2] pulsed in cycle 0 → PEND; no flush while stall_req[4]=1; flush=6'b000011 one cycle after stall_req[4] drops; flush_cnt=1.
- FLUSH_CYCLES=3: flush_req[2] then flush_req[4] during FLUSH → flush widens to 6'b001111 and holds 3 more cycles; flush_cnt=2. A flush_req[1] during FLUSH → ignored, count unchanged.
- rdy=0 for 4 cycles mid-FLUSH (FLUSH_CYCLES=2) → stall=6'b111111, flush=0, counters frozen; after rdy=1 the remaining flush cycle completes.
- Preload flush_cnt to all-ones via a forced value, issue a flush → count stays at all-ones; assert clr_cnt with a simultaneous flush → count=0.
